// File: rtl/lab2_proc_muldiv_unit.sv
// lab2_proc_muldiv_unit: iterative RISC-V M-extension multiply/divide unit,
// one bit of work per cycle, val/rdy request and response streams.
// Ports: clk, reset (async, active-high);
//   istream_val/istream_rdy, istream_msg_op[2:0], istream_msg_a/_b[p_nbits];
//   ostream_val/ostream_rdy, ostream_msg[p_nbits]; busy (CALC or DONE).
// Ops: 0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 REM, 6 REMU, 7 -> result 0.
// Option: LAB2_PROC_MULDIV_EARLY_EXIT_EN enables early exit from CALC.
module lab2_proc_muldiv_unit #(
  parameter int p_nbits    = 32,
  parameter int p_cnt_bits = $clog2(p_nbits) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2:0]         istream_msg_op,
  input  logic [p_nbits-1:0] istream_msg_a,
  input  logic [p_nbits-1:0] istream_msg_b,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] ostream_msg,
  output logic               busy
);

  localparam int N = p_nbits;
  localparam logic [p_cnt_bits-1:0] CntLast = p_cnt_bits'(N - 1);
  localparam logic [p_cnt_bits-1:0] CntOne  = p_cnt_bits'(1);

  localparam logic [2:0] OpMul   = 3'd0;
  localparam logic [2:0] OpMulh  = 3'd1;
  localparam logic [2:0] OpMulhu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpRem   = 3'd5;
  localparam logic [2:0] OpRemu  = 3'd6;
  localparam logic [2:0] OpNone  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]            op_q;
  logic                  neg_q;
  logic                  sign_a_q;
  logic [N-1:0]          a_q;
  logic [N-1:0]          b_q;
  logic [N-1:0]          res_q;
  logic [2*N-1:0]        acc_q;
  logic [p_cnt_bits-1:0] cnt_q;

  logic           req;
  logic           in_signed;
  logic           is_mul;
  logic           div_zero;
  logic           calc_last;
  logic [N-1:0]   a_ld;
  logic [N-1:0]   b_ld;
  logic [N:0]     mul_sum;
  logic [N:0]     div_sh;
  logic [N:0]     div_diff;
  logic           div_ge;
  logic [2*N-1:0] acc_n;
  logic [N-1:0]   a_n;
  logic [N-1:0]   b_n;
  logic [2*N-1:0] prod;
  logic [2*N-1:0] prod_s;
  logic [N-1:0]   quot_s;
  logic [N-1:0]   rem_mag;
  logic [N-1:0]   rem_s;
  logic [N-1:0]   res_d;

  assign req = istream_val && (state_q == ST_IDLE);

  assign in_signed = (istream_msg_op == OpMulh)
                  || (istream_msg_op == OpDiv)
                  || (istream_msg_op == OpRem);

  assign a_ld = (in_signed && istream_msg_a[N-1])
              ? -istream_msg_a : istream_msg_a;
  assign b_ld = (in_signed && istream_msg_b[N-1])
              ? -istream_msg_b : istream_msg_b;

  assign is_mul   = (op_q < OpDiv);
  assign div_zero = (b_q == '0);

  // One iteration. Multiply adds into the upper half and shifts
  // the whole product right; divide shifts the next dividend bit
  // into the partial remainder and shifts quotient bits in at LSB.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*N-1:N]}
             + (b_q[0] ? {1'b0, a_q} : '0);
    div_sh   = {acc_q[2*N-1:N], a_q[N-1]};
    div_diff = div_sh - {1'b0, b_q};
    div_ge   = ~div_diff[N];
    if (is_mul) begin
      acc_n = {mul_sum, acc_q[N-1:1]};
      a_n   = a_q;
      b_n   = b_q >> 1;
    end else begin
      acc_n = {div_ge ? div_diff[N-1:0] : div_sh[N-1:0],
               acc_q[N-2:0], div_ge};
      a_n   = a_q << 1;
      b_n   = b_q;
    end
  end

`ifdef LAB2_PROC_MULDIV_EARLY_EXIT_EN
  assign calc_last = (cnt_q == CntLast)
                  || (is_mul ? (b_n == '0) : div_zero);
`else
  assign calc_last = (cnt_q == CntLast);
`endif

  // Sign fixup on the final iteration's result.
  always_comb begin
`ifdef LAB2_PROC_MULDIV_EARLY_EXIT_EN
    // Skipped multiplier bits were zero; realign the product.
    prod    = acc_n >> (CntLast - cnt_q);
    rem_mag = div_zero ? a_q : acc_n[2*N-1:N];
`else
    prod    = acc_n;
    rem_mag = acc_n[2*N-1:N];
`endif
    prod_s = neg_q ? -prod : prod;
    quot_s = neg_q ? -acc_n[N-1:0] : acc_n[N-1:0];
    rem_s  = sign_a_q ? -rem_mag : rem_mag;
    res_d  = '0;
    unique case (op_q)
      OpMul:           res_d = prod_s[N-1:0];
      OpMulh, OpMulhu: res_d = prod_s[2*N-1:N];
      OpDiv, OpDivu:   res_d = div_zero ? '1 : quot_s;
      OpRem, OpRemu:   res_d = rem_s;
      default:         res_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req)
                 state_d = (istream_msg_op == OpNone)
                         ? ST_DONE : ST_CALC;
      ST_CALC: if (calc_last) state_d = ST_DONE;
      ST_DONE: if (ostream_rdy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (req) begin
          op_q     <= istream_msg_op;
          sign_a_q <= in_signed & istream_msg_a[N-1];
          neg_q    <= in_signed
                    & (istream_msg_a[N-1] ^ istream_msg_b[N-1]);
          a_q      <= a_ld;
          b_q      <= b_ld;
          acc_q    <= '0;
          cnt_q    <= '0;
          if (istream_msg_op == OpNone) res_q <= '0;
        end
        ST_CALC: begin
          acc_q <= acc_n;
          a_q   <= a_n;
          b_q   <= b_n;
          cnt_q <= cnt_q + CntOne;
          if (calc_last) res_q <= res_d;
        end
        default: ;
      endcase
    end
  end

  assign istream_rdy = (state_q == ST_IDLE);
  assign ostream_val = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign ostream_msg = res_q;

endmodule

// File: tb/tb_lab2_proc_muldiv_unit.sv
// tb_lab2_proc_muldiv_unit: directed and random checks of the muldiv
// unit against an arithmetic reference model (results and latency).
module tb_lab2_proc_muldiv_unit;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         istream_val = 1'b0;
  logic         istream_rdy;
  logic [2:0]   istream_msg_op = '0;
  logic [N-1:0] istream_msg_a = '0;
  logic [N-1:0] istream_msg_b = '0;
  logic         ostream_val;
  logic         ostream_rdy = 1'b0;
  logic [N-1:0] ostream_msg;
  logic         busy;

  int total = 0;
  int bad = 0;

  lab2_proc_muldiv_unit #(.p_nbits(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .istream_val    (istream_val),
    .istream_rdy    (istream_rdy),
    .istream_msg_op (istream_msg_op),
    .istream_msg_a  (istream_msg_a),
    .istream_msg_b  (istream_msg_b),
    .ostream_val    (ostream_val),
    .ostream_rdy    (ostream_rdy),
    .ostream_msg    (ostream_msg),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] p;
    p = '0;
    case (op)
      3'd0: begin p = 64'(a) * 64'(b); return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = 64'(a) * 64'(b); return p[63:32]; end
      3'd3: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd5: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        return a % b;
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op,
                                 input logic [31:0] b);
    logic [31:0] mb;
    mb = (op == 3'd1 && b[31]) ? -b : b;
    if (op == 3'd7) return 1;
`ifdef LAB2_PROC_MULDIV_EARLY_EXIT_EN
    if (op < 3'd3) begin
      for (int i = 31; i >= 0; i--)
        if (mb[i]) return i + 2;
      return 2;
    end
    if (b == 0) return 2;
`endif
    return N + 1;
  endfunction

  task automatic run_op(input string tag,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int hold);
    int lat;
    @(negedge clk);
    check({tag, "/in_rdy"}, 32'(istream_rdy), 32'd1);
    istream_val    = 1'b1;
    istream_msg_op = op;
    istream_msg_a  = a;
    istream_msg_b  = b;
    ostream_rdy    = (hold == 0);
    @(posedge clk);
    #1;
    istream_val    = 1'b0;
    istream_msg_op = 3'($urandom);
    istream_msg_a  = $urandom;
    istream_msg_b  = $urandom;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check({tag, "/busy"}, 32'(busy), 32'd1);
        check({tag, "/rdy_lo"}, 32'(istream_rdy), 32'd0);
      end
      if (ostream_val) break;
    end
    check({tag, "/lat"}, 32'(lat), 32'(ref_lat(op, b)));
    check({tag, "/res"}, ostream_msg, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold_val"}, 32'(ostream_val), 32'd1);
      check({tag, "/hold_msg"}, ostream_msg, exp);
      check({tag, "/hold_rdy"}, 32'(istream_rdy), 32'd0);
      check({tag, "/hold_busy"}, 32'(busy), 32'd1);
    end
    ostream_rdy = 1'b1;
    @(negedge clk);
    check({tag, "/val_lo"}, 32'(ostream_val), 32'd0);
    check({tag, "/rdy_hi"}, 32'(istream_rdy), 32'd1);
    ostream_rdy = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int stale;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (3) @(negedge clk);
    check("rst/in_rdy", 32'(istream_rdy), 32'd1);
    check("rst/out_val", 32'(ostream_val), 32'd0);
    check("rst/out_msg", ostream_msg, 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    reset = 1'b0;

    run_op("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 0);
    run_op("mulhu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 0);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem_neg", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("divu", 3'd4, 32'd100, 32'd7, 32'd14, 0);
    run_op("remu", 3'd6, 32'd100, 32'd7, 32'd2, 0);
    run_op("div_z", 3'd3, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem_z", 3'd5, 32'd5, 32'd0, 32'd5, 0);
    run_op("div_nz", 3'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem_nz", 3'd5, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 0);
    run_op("rem_ovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("mul_small", 3'd0, 32'h1234, 32'd3, 32'h369C, 0);
    run_op("divu_z", 3'd4, 32'd9, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("op7", 3'd7, 32'd55, 32'd66, 32'd0, 0);
    run_op("hold", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 5);

    // Abort an operation in its 10th CALC cycle.
    @(negedge clk);
    istream_val    = 1'b1;
    istream_msg_op = 3'd4;
    istream_msg_a  = 32'd1000;
    istream_msg_b  = 32'd3;
    ostream_rdy    = 1'b1;
    @(posedge clk);
    #1;
    istream_val = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort/out_val", 32'(ostream_val), 32'd0);
    check("abort/in_rdy", 32'(istream_rdy), 32'd1);
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/out_msg", ostream_msg, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (ostream_val) stale++;
    end
    check("abort/stale", 32'(stale), 32'd0);
    ostream_rdy = 1'b0;

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb,
             ref_result(rop, ra, rb), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
